// File: rtl/led_scan_pkg.sv
// Shared scan-controller types and constants: FSM state encoding and brightness width.
package led_scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  localparam int unsigned BRIGHT_WIDTH = 4;

endpackage

// File: rtl/led_scan_timer.sv
// Row scan sequencer: BLANK/DRIVE phase FSM, dwell counter and row index.
// Exposes next-cycle values so the owner can register its outputs in step with the state.
module led_scan_timer
  import led_scan_pkg::*;
#(
  parameter int unsigned NUM_ROWS       = 4,
  parameter int unsigned NUM_ROWS_WIDTH = 2,
  parameter int unsigned BLANK_TICKS    = 4,
  parameter int unsigned DWELL_WIDTH    = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output scan_state_e               state_nxt_c,
  output logic [NUM_ROWS_WIDTH-1:0] row_nxt_c,
  output logic [DWELL_WIDTH-1:0]    cnt_nxt_c,
  output logic                      drive_entry_c,
  output logic                      frame_start_c,
  output logic                      frame_end_c
);

  localparam scan_state_e ENTRY_STATE = (BLANK_TICKS == 0) ? DRIVE : BLANK;
  localparam logic [DWELL_WIDTH-1:0] BLANK_LAST =
    DWELL_WIDTH'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [NUM_ROWS_WIDTH-1:0] ROW_LAST = NUM_ROWS_WIDTH'(NUM_ROWS - 1);

  scan_state_e               state;
  logic [NUM_ROWS_WIDTH-1:0] row;
  logic [DWELL_WIDTH-1:0]    cnt;
  logic                      run;

  // run is low only during reset so the first edge after release enters row 0 afresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      state <= BLANK;
      row   <= '0;
      cnt   <= '0;
    end else begin
      run   <= 1'b1;
      state <= state_nxt_c;
      row   <= row_nxt_c;
      cnt   <= cnt_nxt_c;
    end
  end

  always_comb begin
    state_nxt_c   = state;
    row_nxt_c     = row;
    cnt_nxt_c     = cnt + DWELL_WIDTH'(1);
    drive_entry_c = 1'b0;
    frame_start_c = 1'b0;
    frame_end_c   = 1'b0;
    if (!run) begin
      state_nxt_c   = ENTRY_STATE;
      row_nxt_c     = '0;
      cnt_nxt_c     = '0;
      frame_start_c = 1'b1;
      drive_entry_c = (ENTRY_STATE == DRIVE);
    end else begin
      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt_c   = DRIVE;
            cnt_nxt_c     = '0;
            drive_entry_c = 1'b1;
          end
        end
        DRIVE: begin
          if (&cnt) begin
            state_nxt_c   = ENTRY_STATE;
            cnt_nxt_c     = '0;
            drive_entry_c = (ENTRY_STATE == DRIVE);
            if (row == ROW_LAST) begin
              row_nxt_c     = '0;
              frame_start_c = 1'b1;
              frame_end_c   = 1'b1;
            end else begin
              row_nxt_c = row + NUM_ROWS_WIDTH'(1);
            end
          end
        end
        default: state_nxt_c = BLANK;
      endcase
    end
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// Multiplexed LED matrix scanner with double-buffered frame storage and frame-aligned swap.
// Build option: define LED_SCAN_CTRL_PWM_EN for per-row brightness PWM from i_bright.
module led_scan_ctrl
  import led_scan_pkg::*;
#(
  parameter int unsigned NUM_ROWS              = 4,
  parameter int unsigned NUM_ROWS_WIDTH        = 2,
  parameter int unsigned NUM_COLS              = 8,
  parameter int unsigned BLANK_TICKS           = 4,
  parameter int unsigned DWELL_WIDTH           = 10,
  parameter int unsigned ROW_OUTPUT_ACTIVE_LOW = 0,
  parameter int unsigned COL_OUTPUT_ACTIVE_LOW = 0
) (
  input  logic                      clk,
  input  logic                      i_rst_n,
  input  logic                      i_wr_en,
  input  logic [NUM_ROWS_WIDTH-1:0] i_wr_row,
  input  logic [NUM_COLS-1:0]       i_wr_data,
  input  logic                      i_swap_req,
  input  logic [BRIGHT_WIDTH-1:0]   i_bright,
  output logic                      o_swap_ack,
  output logic                      o_frame_start,
  output logic [NUM_ROWS_WIDTH-1:0] o_row_idx,
  output logic [NUM_ROWS-1:0]       o_rows,
  output logic [NUM_COLS-1:0]       o_cols
);

  localparam logic ROW_INV = (ROW_OUTPUT_ACTIVE_LOW != 0);
  localparam logic COL_INV = (COL_OUTPUT_ACTIVE_LOW != 0);

  scan_state_e               state_nxt_c;
  logic [NUM_ROWS_WIDTH-1:0] row_nxt_c;
  logic [DWELL_WIDTH-1:0]    cnt_nxt_c;
  logic                      drive_entry_c;
  logic                      frame_start_c;
  logic                      frame_end_c;

  led_scan_timer #(
    .NUM_ROWS      (NUM_ROWS),
    .NUM_ROWS_WIDTH(NUM_ROWS_WIDTH),
    .BLANK_TICKS   (BLANK_TICKS),
    .DWELL_WIDTH   (DWELL_WIDTH)
  ) u_timer (
    .clk          (clk),
    .rst_n        (i_rst_n),
    .state_nxt_c  (state_nxt_c),
    .row_nxt_c    (row_nxt_c),
    .cnt_nxt_c    (cnt_nxt_c),
    .drive_entry_c(drive_entry_c),
    .frame_start_c(frame_start_c),
    .frame_end_c  (frame_end_c)
  );

  logic [NUM_COLS-1:0] fb [2][NUM_ROWS];
  logic                front_sel;
  logic                armed;
  logic                swap_c;
  logic                front_sel_nxt_c;
  logic                wr_ok_c;
  logic [NUM_COLS-1:0] row_data_c;
  logic                pwm_on_c;
  logic [NUM_ROWS-1:0] rows_c;
  logic [NUM_COLS-1:0] cols_c;

  assign swap_c          = frame_end_c && i_swap_req && armed;
  assign front_sel_nxt_c = front_sel ^ swap_c;
  assign wr_ok_c         = i_wr_en && (32'(i_wr_row) < NUM_ROWS);

  // A write on the swap edge targets the buffer about to become front; forward it
  assign row_data_c = (swap_c && wr_ok_c && (i_wr_row == row_nxt_c)) ? i_wr_data
                                                                     : fb[front_sel_nxt_c][row_nxt_c];

`ifdef LED_SCAN_CTRL_PWM_EN
  logic [BRIGHT_WIDTH-1:0] bright_q;
  logic [BRIGHT_WIDTH-1:0] bright_c;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bright_q <= '0;
    end else if (drive_entry_c) begin
      bright_q <= i_bright;
    end
  end

  assign bright_c = drive_entry_c ? i_bright : bright_q;
  assign pwm_on_c = (cnt_nxt_c[DWELL_WIDTH-1 -: BRIGHT_WIDTH] < bright_c);
`else
  logic unused_c;
  assign unused_c = ^{i_bright, cnt_nxt_c, drive_entry_c};
  assign pwm_on_c = 1'b1;
`endif

  assign rows_c = (state_nxt_c == DRIVE) ? (NUM_ROWS'(1) << row_nxt_c) : '0;
  assign cols_c = ((state_nxt_c == DRIVE) && pwm_on_c) ? row_data_c : '0;

  // Registered outputs and swap handshake, aligned with the timer state
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rows        <= {NUM_ROWS{ROW_INV}};
      o_cols        <= {NUM_COLS{COL_INV}};
      o_swap_ack    <= 1'b0;
      o_frame_start <= 1'b0;
      o_row_idx     <= '0;
      front_sel     <= 1'b0;
      armed         <= 1'b1;
    end else begin
      o_rows        <= rows_c ^ {NUM_ROWS{ROW_INV}};
      o_cols        <= cols_c ^ {NUM_COLS{COL_INV}};
      o_swap_ack    <= swap_c;
      o_frame_start <= frame_start_c;
      o_row_idx     <= row_nxt_c;
      front_sel     <= front_sel_nxt_c;
      if (swap_c) begin
        armed <= 1'b0;
      end else if (!i_swap_req) begin
        armed <= 1'b1;
      end
    end
  end

  // Host writes always go to the buffer not selected at this edge
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < int'(NUM_ROWS); r++) begin
        fb[0][r] <= '0;
        fb[1][r] <= '0;
      end
    end else if (wr_ok_c) begin
      fb[~front_sel][i_wr_row] <= i_wr_data;
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl: frame-position reference model, directed swap/PWM/reset
// scenarios and randomized traffic, checked on a normal and an inverted-polarity instance.
module tb_led_scan_ctrl;

  localparam int unsigned NR = 4;
  localparam int unsigned NC = 8;
  localparam int unsigned BT = 2;
  localparam int unsigned DW = 5;
  localparam int ROW_P = int'(BT) + (1 << DW);
  localparam int FRAME = int'(NR) * ROW_P;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_row;
  logic [7:0] wr_data;
  logic       swap_req;
  logic [3:0] bright;

  logic       swap_ack, frame_start;
  logic [1:0] row_idx;
  logic [3:0] rows;
  logic [7:0] cols;
  logic       inv_swap_ack, inv_frame_start;
  logic [1:0] inv_row_idx;
  logic [3:0] inv_rows;
  logic [7:0] inv_cols;

  always #5 clk = ~clk;

  led_scan_ctrl #(
    .NUM_ROWS(NR), .NUM_ROWS_WIDTH(2), .NUM_COLS(NC), .BLANK_TICKS(BT), .DWELL_WIDTH(DW),
    .ROW_OUTPUT_ACTIVE_LOW(0), .COL_OUTPUT_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_row(wr_row), .i_wr_data(wr_data),
    .i_swap_req(swap_req), .i_bright(bright), .o_swap_ack(swap_ack),
    .o_frame_start(frame_start), .o_row_idx(row_idx), .o_rows(rows), .o_cols(cols)
  );

  led_scan_ctrl #(
    .NUM_ROWS(NR), .NUM_ROWS_WIDTH(2), .NUM_COLS(NC), .BLANK_TICKS(BT), .DWELL_WIDTH(DW),
    .ROW_OUTPUT_ACTIVE_LOW(1), .COL_OUTPUT_ACTIVE_LOW(1)
  ) dut_inv (
    .clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_row(wr_row), .i_wr_data(wr_data),
    .i_swap_req(swap_req), .i_bright(bright), .o_swap_ack(inv_swap_ack),
    .o_frame_start(inv_frame_start), .o_row_idx(inv_row_idx), .o_rows(inv_rows), .o_cols(inv_cols)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: visible cycle index since reset release plus two frame arrays
  bit         started;
  int         t;
  logic [7:0] fr [NR];
  logic [7:0] bk [NR];
  bit         armed_m;
  bit         ack_m;
  logic [3:0] bright_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    started  = 1'b0;
    t        = 0;
    armed_m  = 1'b1;
    ack_m    = 1'b0;
    bright_m = '0;
    foreach (fr[i]) begin
      fr[i] = '0;
      bk[i] = '0;
    end
  endtask

  task automatic model_edge();
    bit         commit;
    logic [7:0] tmp;
    if (!rst_n) return;
    commit = started && ((t % FRAME) == FRAME - 1) && swap_req && armed_m;
    if (started) t++;
    else begin
      started = 1'b1;
      t = 0;
    end
    if (wr_en) bk[wr_row] = wr_data;
    if (commit) armed_m = 1'b0;
    else if (!swap_req) armed_m = 1'b1;
    if (commit) begin
      foreach (fr[i]) begin
        tmp = fr[i];
        fr[i] = bk[i];
        bk[i] = tmp;
      end
    end
    ack_m = commit;
    if (((t % FRAME) % ROW_P) == int'(BT)) bright_m = bright;
  endtask

  task automatic compare_all();
    logic [3:0] er, er_n;
    logic [7:0] ec, ec_n;
    logic [1:0] eri;
    bit         efs, on;
    int         pos, r, off, dwell;
    er = '0; ec = '0; eri = '0; efs = 1'b0;
    if (started) begin
      pos = t % FRAME;
      r   = pos / ROW_P;
      off = pos % ROW_P;
      eri = 2'(r);
      efs = (pos == 0);
      if (off >= int'(BT)) begin
        dwell = off - int'(BT);
        er = 4'(1 << r);
        on = 1'b1;
`ifdef LED_SCAN_CTRL_PWM_EN
        on = ((dwell >> (DW - 4)) < int'(bright_m));
`endif
        ec = on ? fr[r] : 8'h00;
      end
    end
    er_n = ~er;
    ec_n = ~ec;
    check("rows", 32'(rows), 32'(er));
    check("cols", 32'(cols), 32'(ec));
    check("row_idx", 32'(row_idx), 32'(eri));
    check("frame_start", 32'(frame_start), 32'(efs));
    check("swap_ack", 32'(swap_ack), 32'(ack_m));
    check("inv_rows", 32'(inv_rows), 32'(er_n));
    check("inv_cols", 32'(inv_cols), 32'(ec_n));
    check("inv_row_idx", 32'(inv_row_idx), 32'(eri));
    check("inv_frame_start", 32'(inv_frame_start), 32'(efs));
    check("inv_swap_ack", 32'(inv_swap_ack), 32'(ack_m));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Advance to the next visible cycle at frame position p
  task automatic run_until(input int p);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(started && ((t % FRAME) == p)) && n < 2 * FRAME);
    if (n >= 2 * FRAME) check("wait_timeout", 32'(n), 32'(0));
  endtask

  task automatic apply_reset(input int hold);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (hold) tick();
    rst_n = 1'b1;
  endtask

  logic [7:0] pat [4];
  int         cnt;
  int         exp_cnt;

  initial begin
    pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'hFF; pat[3] = 8'h01;
    wr_en = 1'b0; wr_row = '0; wr_data = '0; swap_req = 1'b0; bright = 4'hF;
    rst_n = 1'b1;
    model_reset();
    #2;
    apply_reset(3);

    tick();
    check("first_frame_start", 32'(frame_start), 32'(1));
    run_until(0);
    check("period_frame_start", 32'(frame_start), 32'(1));

    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_row = 2'(i); wr_data = pat[i];
      tick();
    end
    wr_en = 1'b0;
    run_until(50);
    swap_req = 1'b1;
    run_until(0);
    check("ack_after_frame", 32'(swap_ack), 32'(1));

    run_until(int'(BT));
    check("row0_shows_A5", 32'(cols), 32'(8'hA5));

    bright = 4'd8;
    run_until(2 * ROW_P + int'(BT) - 1);
    cnt = 0;
    repeat (1 << DW) begin
      tick();
      if (cols == 8'hFF) cnt++;
    end
`ifdef LED_SCAN_CTRL_PWM_EN
    exp_cnt = 16;
`else
    exp_cnt = 32;
`endif
    check("pwm_bright8_on_cycles", 32'(cnt), 32'(exp_cnt));

    bright = 4'd0;
    run_until(3 * ROW_P + int'(BT) - 1);
    cnt = 0;
    repeat (1 << DW) begin
      tick();
      if (cols == 8'h01) cnt++;
    end
`ifdef LED_SCAN_CTRL_PWM_EN
    exp_cnt = 0;
`else
    exp_cnt = 32;
`endif
    check("pwm_bright0_on_cycles", 32'(cnt), 32'(exp_cnt));
    bright = 4'hF;

    run_until(0);
    check("no_ack_while_held", 32'(swap_ack), 32'(0));
    run_until(20);
    swap_req = 1'b0;
    tick();
    swap_req = 1'b1;
    run_until(FRAME - 1);
    wr_en = 1'b1; wr_row = 2'd2; wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    check("rearmed_ack", 32'(swap_ack), 32'(1));
    run_until(2 * ROW_P + int'(BT));
    check("swap_edge_write_shown", 32'(cols), 32'(8'h5A));

    run_until(40);
    swap_req = 1'b0;
    tick();
    swap_req = 1'b1;
    run_until(70);
    apply_reset(3);
    check("reset_no_ack", 32'(swap_ack), 32'(0));
    tick();
    check("restart_frame_start", 32'(frame_start), 32'(1));
    swap_req = 1'b0;

    repeat (8 * FRAME) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_row  = 2'($urandom_range(0, 3));
      wr_data = 8'($urandom);
      if ($urandom_range(0, 39) == 0) swap_req = ~swap_req;
      if ($urandom_range(0, 19) == 0) bright = 4'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
